// File: rtl/raw_forward_scoreboard.sv
// raw_forward_scoreboard
//
// Read-after-write hazard unit for the write-back path. An in-order pending
// FIFO tracks issued but uncommitted register writes. A short history of
// recent write-backs covers the register-file write-to-read latency.
// Operand requests stall while a source has an outstanding write. Otherwise
// they return the freshest value one cycle later.
//
// Parameters
//   DATA_W  operand/result width
//   ADDR_W  register address width
//   HIST    write-back history depth (>= 1)
//   PEND    max outstanding issued writes (power of two, >= 2)
//
// Ports
//   Clock, Reset_n                  clock, async active-low reset
//   Issue_Valid/Issue_Dest          issued write destination
//   Issue_Ready                     scoreboard can accept an issue
//   WB_Valid/WB_Add/WB_Data         in-order commit of the oldest write
//   Req_Valid/Req_Ready             operand read handshake
//   Source_Add1/2, SourceD1/2       source registers and (possibly stale) RF data
//   Data1/Data2, Out_Valid          resolved operands, registered
//   Err                             sticky: out-of-order WB or WB with nothing pending
//
// Optional feature macro: RAW_ZERO_REG_EN. When it is defined, register 0 is
// hardwired zero. It never hazards, it always reads 0 and it is never forwarded.

module raw_forward_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int HIST   = 3,
  parameter int PEND   = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Dest,
  output logic              Issue_Ready,
  input  logic              WB_Valid,
  input  logic [ADDR_W-1:0] WB_Add,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic [ADDR_W-1:0] Source_Add1,
  input  logic [ADDR_W-1:0] Source_Add2,
  input  logic [DATA_W-1:0] SourceD1,
  input  logic [DATA_W-1:0] SourceD2,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic              Out_Valid,
  output logic              Err
);

  localparam int PTR_W = (PEND > 1) ? $clog2(PEND) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PEND);

  // Pending-write FIFO
  logic [ADDR_W-1:0] fifo [PEND];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  // Write-back history, index 0 is the newest entry
  logic [HIST-1:0]   hist_vld;
  logic [ADDR_W-1:0] hist_addr [HIST];
  logic [DATA_W-1:0] hist_data [HIST];

  logic              empty;
  logic              push;
  logic              pop;
  logic              wb_bad;
  logic              hazard1;
  logic              hazard2;
  logic              accept;
  logic [DATA_W-1:0] resolved1;
  logic [DATA_W-1:0] resolved2;
  logic [ADDR_W-1:0] head;

  assign head  = fifo[rd_ptr];
  assign empty = (count == '0);
  assign pop   = WB_Valid && !empty;
  // A commit with nothing pending, or one that does not match the oldest
  // issue, means the pipeline has lost write ordering.
  assign wb_bad = WB_Valid && (empty || (WB_Add != head));
  // When the FIFO is full, a commit in the same cycle frees the slot the push needs.
  assign Issue_Ready = (count < FULL) || WB_Valid;
  assign push        = Issue_Valid && Issue_Ready;

  // An entry blocks a source unless it is the head that commits this cycle
  // to that same register. The live WB port then supplies the value.
  // A duplicate destination further back keeps the hazard alive.
  function automatic logic src_hazard(input logic [ADDR_W-1:0] src);
    logic             hit;
    logic [PTR_W-1:0] idx;
    hit = 1'b0;
    for (int i = 0; i < PEND; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo[idx] == src) &&
          !((i == 0) && pop && (WB_Add == src)))
        hit = 1'b1;
    end
`ifdef RAW_ZERO_REG_EN
    if (src == '0)
      hit = 1'b0;
`endif
    return hit;
  endfunction

  // Freshest value: live WB port, then the history from newest to oldest,
  // then the register file.
  function automatic logic [DATA_W-1:0] resolve(input logic [ADDR_W-1:0] src,
                                                input logic [DATA_W-1:0] rf);
    logic [DATA_W-1:0] val;
    logic              found;
    val   = rf;
    found = 1'b0;
    if (WB_Valid && (WB_Add == src)) begin
      val   = WB_Data;
      found = 1'b1;
    end
    for (int i = 0; i < HIST; i++) begin
      if (!found && hist_vld[i] && (hist_addr[i] == src)) begin
        val   = hist_data[i];
        found = 1'b1;
      end
    end
`ifdef RAW_ZERO_REG_EN
    if (src == '0)
      val = '0;
`endif
    return val;
  endfunction

  always_comb begin
    hazard1   = src_hazard(Source_Add1);
    hazard2   = src_hazard(Source_Add2);
    resolved1 = resolve(Source_Add1, SourceD1);
    resolved2 = resolve(Source_Add2, SourceD2);
  end

  assign Req_Ready = !(hazard1 || hazard2);
  assign accept    = Req_Valid && Req_Ready;

  // Control state, pointers, history valids and output registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      Err       <= 1'b0;
      Out_Valid <= 1'b0;
      Data1     <= '0;
      Data2     <= '0;
      hist_vld  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wb_bad)
        Err <= 1'b1;
      Out_Valid <= accept;
      if (accept) begin
        Data1 <= resolved1;
        Data2 <= resolved2;
      end
      for (int i = HIST - 1; i > 0; i--)
        hist_vld[i] <= hist_vld[i-1];
      hist_vld[0] <= WB_Valid;
    end
  end

  // FIFO storage and history payload: contents only matter behind a valid
  always_ff @(posedge Clock) begin
    if (push)
      fifo[wr_ptr] <= Issue_Dest;
    for (int i = HIST - 1; i > 0; i--) begin
      hist_addr[i] <= hist_addr[i-1];
      hist_data[i] <= hist_data[i-1];
    end
    hist_addr[0] <= WB_Add;
    hist_data[0] <= WB_Data;
  end

endmodule

// File: tb/tb_raw_forward_scoreboard.sv
module tb_raw_forward_scoreboard;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int HIST   = 3;
  localparam int PEND   = 4;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              Issue_Valid;
  logic [ADDR_W-1:0] Issue_Dest;
  logic              Issue_Ready;
  logic              WB_Valid;
  logic [ADDR_W-1:0] WB_Add;
  logic [DATA_W-1:0] WB_Data;
  logic              Req_Valid;
  logic              Req_Ready;
  logic [ADDR_W-1:0] Source_Add1;
  logic [ADDR_W-1:0] Source_Add2;
  logic [DATA_W-1:0] SourceD1;
  logic [DATA_W-1:0] SourceD2;
  logic [DATA_W-1:0] Data1;
  logic [DATA_W-1:0] Data2;
  logic              Out_Valid;
  logic              Err;

  always #5 Clock = ~Clock;

  raw_forward_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HIST(HIST), .PEND(PEND)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Issue_Valid(Issue_Valid), .Issue_Dest(Issue_Dest), .Issue_Ready(Issue_Ready),
    .WB_Valid(WB_Valid), .WB_Add(WB_Add), .WB_Data(WB_Data),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Source_Add1(Source_Add1), .Source_Add2(Source_Add2),
    .SourceD1(SourceD1), .SourceD2(SourceD2),
    .Data1(Data1), .Data2(Data2), .Out_Valid(Out_Valid), .Err(Err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } hent_t;

  logic [ADDR_W-1:0] pq[$];   // outstanding writes, oldest first
  hent_t             hq[$];   // recent write-backs, newest first
  logic [DATA_W-1:0] m_d1, m_d2;
  logic              m_ov, m_err;

  task automatic model_reset();
    hent_t e;
    e = '0;
    pq.delete();
    hq.delete();
    for (int i = 0; i < HIST; i++) hq.push_back(e);
    m_d1 = '0; m_d2 = '0; m_ov = 1'b0; m_err = 1'b0;
  endtask

  function automatic logic m_hazard(input logic [ADDR_W-1:0] s);
    int n;
    n = 0;
`ifdef RAW_ZERO_REG_EN
    if (s == '0) return 1'b0;
`endif
    foreach (pq[i]) if (pq[i] == s) n++;
    if (WB_Valid && pq.size() > 0 && pq[0] == s && WB_Add == s) n--;
    return n > 0;
  endfunction

  function automatic logic [DATA_W-1:0] m_resolve(input logic [ADDR_W-1:0] s,
                                                  input logic [DATA_W-1:0] rf);
`ifdef RAW_ZERO_REG_EN
    if (s == '0) return '0;
`endif
    if (WB_Valid && WB_Add == s) return WB_Data;
    foreach (hq[i]) if (hq[i].v && hq[i].a == s) return hq[i].d;
    return rf;
  endfunction

  function automatic logic m_req_ready();
    return !(m_hazard(Source_Add1) || m_hazard(Source_Add2));
  endfunction

  function automatic logic m_issue_ready();
    return (pq.size() < PEND) || WB_Valid;
  endfunction

  task automatic model_step();
    logic  rdy, irdy;
    hent_t e;
    rdy  = m_req_ready();
    irdy = m_issue_ready();
    if (Req_Valid && rdy) begin
      m_d1 = m_resolve(Source_Add1, SourceD1);
      m_d2 = m_resolve(Source_Add2, SourceD2);
      m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    if (WB_Valid) begin
      if (pq.size() == 0 || pq[0] != WB_Add) m_err = 1'b1;
      if (pq.size() > 0) void'(pq.pop_front());
    end
    if (Issue_Valid && irdy) pq.push_back(Issue_Dest);
    e.v = WB_Valid; e.a = WB_Add; e.d = WB_Data;
    hq.push_front(e);
    void'(hq.pop_back());
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic settle();
    #1;
    chk("issue_ready", Issue_Ready, m_issue_ready());
    chk("req_ready",   Req_Ready,   m_req_ready());
    chk("out_valid",   Out_Valid,   m_ov);
    chk("err",         Err,         m_err);
    chk("data1",       Data1,       m_d1);
    chk("data2",       Data2,       m_d2);
  endtask

  task automatic advance();
    model_step();
    @(negedge Clock);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle();
    Issue_Valid = 1'b0; Issue_Dest = '0;
    WB_Valid = 1'b0; WB_Add = '0; WB_Data = '0;
    Req_Valid = 1'b0; Source_Add1 = 8'd1; Source_Add2 = 8'd1;
    SourceD1 = '0; SourceD2 = '0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] d);
    idle(); Issue_Valid = 1'b1; Issue_Dest = d;
  endtask

  task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    idle(); WB_Valid = 1'b1; WB_Add = a; WB_Data = d;
  endtask

  task automatic random_cycle(input bit allow_bad);
    idle();
    Issue_Valid = ($urandom_range(0, 2) == 0);
    Issue_Dest  = ADDR_W'($urandom_range(0, 7));
    WB_Data     = DATA_W'($urandom);
    if (pq.size() > 0 && $urandom_range(0, 2) == 0) begin
      WB_Valid = 1'b1;
      WB_Add   = pq[0];
    end
    if (allow_bad && $urandom_range(0, 15) == 0) begin
      WB_Valid = 1'b1;
      WB_Add   = ADDR_W'($urandom_range(0, 7));
    end
    Req_Valid   = $urandom_range(0, 1) == 1;
    Source_Add1 = ADDR_W'($urandom_range(0, 7));
    Source_Add2 = ADDR_W'($urandom_range(0, 7));
    SourceD1    = DATA_W'($urandom);
    SourceD2    = DATA_W'($urandom);
    tick();
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    // Reset state, then a plain request with nothing pending
    settle();
    chk("rst_out_valid",   Out_Valid,   1'b0);
    chk("rst_err",         Err,         1'b0);
    chk("rst_data1",       Data1,       16'h0000);
    chk("rst_issue_ready", Issue_Ready, 1'b1);
    chk("rst_req_ready",   Req_Ready,   1'b1);
    advance();
    idle(); Req_Valid = 1'b1; Source_Add1 = 8'd3; Source_Add2 = 8'd4;
    SourceD1 = 16'h1111; SourceD2 = 16'h2222;
    settle();
    chk("t1_req_ready", Req_Ready, 1'b1);
    advance();
    idle(); settle();
    chk("t1_data1", Data1, 16'h1111);
    chk("t1_data2", Data2, 16'h2222);
    chk("t1_ovld",  Out_Valid, 1'b1);
    advance();

    // Stall on pending write to 5 until it commits; forwarded from the WB port
    issue(8'd5); tick();
    for (int k = 0; k < 3; k++) begin
      idle(); Req_Valid = 1'b1; Source_Add1 = 8'd5; Source_Add2 = 8'd6;
      settle();
      chk("t2_stall", Req_Ready, 1'b0);
      advance();
    end
    wb(8'd5, 16'hBEEF); Req_Valid = 1'b1; Source_Add1 = 8'd5; Source_Add2 = 8'd6;
    settle();
    chk("t2_unblock", Req_Ready, 1'b1);
    advance();
    idle(); settle();
    chk("t2_data1", Data1, 16'hBEEF);
    advance();

    // History forwarding window
    issue(8'd7); tick();
    wb(8'd7, 16'hA5A5); tick();
    for (int k = 1; k <= HIST + 2; k++) begin
      idle();
      if (k <= HIST + 1) begin
        Req_Valid = 1'b1; Source_Add1 = 8'd1; Source_Add2 = 8'd7; SourceD2 = 16'h0000;
      end
      settle();
      if (k >= 2)
        chk("t3_hist_data2", Data2, (k - 1 <= HIST) ? 16'hA5A5 : 16'h0000);
      advance();
    end

    // Full FIFO, then push with a simultaneous in-order commit
    for (int k = 1; k <= PEND; k++) begin issue(ADDR_W'(k)); tick(); end
    issue(8'd9); settle();
    chk("t4_full", Issue_Ready, 1'b0);
    advance();
    issue(8'd9); WB_Valid = 1'b1; WB_Add = 8'd1; WB_Data = 16'h0001; settle();
    chk("t4_full_wb", Issue_Ready, 1'b1);
    advance();
    issue(8'd10); settle();
    chk("t4_still_full", Issue_Ready, 1'b0);
    advance();
    wb(8'd2, 16'h2); tick();
    wb(8'd3, 16'h3); tick();
    wb(8'd4, 16'h4); tick();
    wb(8'd9, 16'h9); tick();
    idle(); settle();
    chk("t4_no_err", Err, 1'b0);
    advance();

    // Out-of-order commit makes Err sticky
    issue(8'd2); tick();
    issue(8'd3); tick();
    wb(8'd3, 16'h33); tick();
    idle(); settle();
    chk("t5_err", Err, 1'b1);
    advance();
    wb(8'd3, 16'h34); tick();
    idle(); settle();
    chk("t5_err_sticky", Err, 1'b1);
    advance();

    // Reset in the middle of a stall
    issue(8'd8); tick();
    idle(); Req_Valid = 1'b1; Source_Add1 = 8'd8; settle();
    chk("t6_stalled", Req_Ready, 1'b0);
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_req_ready", Req_Ready, 1'b1);
    chk("t6_rst_err",       Err,       1'b0);
    chk("t6_rst_ovld",      Out_Valid, 1'b0);
    model_reset();
    @(negedge Clock);
    Reset_n = 1'b1;
    idle();

    // Register 0 behaviour
    issue(8'd0); tick();
    idle(); Req_Valid = 1'b1; Source_Add1 = 8'd0; SourceD1 = 16'hFFFF; settle();
`ifdef RAW_ZERO_REG_EN
    chk("t7_zero_ready", Req_Ready, 1'b1);
    advance();
    wb(8'd0, 16'h1234); settle();
    chk("t7_zero_data", Data1, 16'h0000);
    advance();
`else
    chk("t7_zero_stall", Req_Ready, 1'b0);
    advance();
    wb(8'd0, 16'h1234); Req_Valid = 1'b1; Source_Add1 = 8'd0; SourceD1 = 16'hFFFF; settle();
    chk("t7_zero_wb_ready", Req_Ready, 1'b1);
    advance();
    idle(); settle();
    chk("t7_zero_data", Data1, 16'h1234);
    advance();
`endif

    // Random traffic, in-order commits only
    for (int k = 0; k < 1500; k++) random_cycle(1'b0);
    // Random traffic that may commit out of order
    for (int k = 0; k < 300; k++) random_cycle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raw_forward_scoreboard.md
# raw_forward_scoreboard

Parametrised read-after-write hazard unit for the write-back path. It combines an in-order scoreboard of outstanding register writes with a forwarding history of recent write-backs. Operand reads are stalled while any source register has an issued but uncommitted write, and otherwise return the freshest value with a one-cycle registered latency. It sits between the register-file read port and the execute stage.

## Interface
- DATA_W, 16, operand/result width
- ADDR_W, 8, register address width
- HIST, 3, write-back history depth (register-file write-to-read latency), ≥1
- PEND, 4, max outstanding issued writes, power of two ≥2
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Issue_Valid  in  1  instruction with register write issued
- Issue_Dest  in  ADDR_W  its destination register
- Issue_Ready  out  1  scoreboard can accept an issue
- WB_Valid  in  1  oldest outstanding write commits this cycle
- WB_Add  in  ADDR_W  committing register
- WB_Data  in  DATA_W  committing value
- Req_Valid  in  1  operand read request
- Req_Ready  out  1  request accepted this cycle
- Source_Add1, Source_Add2  in  ADDR_W  source registers
- SourceD1, SourceD2  in  DATA_W  register-file read data (may be stale)
- Data1, Data2  out  DATA_W  resolved operands, registered
- Out_Valid  out  1  Data1/Data2 valid
- Err  out  1  sticky: WB out of order or WB with empty scoreboard

## Operation
- Pending FIFO, PEND entries of {addr}; count 0..PEND. Issue accepted when Issue_Valid && Issue_Ready; pushes Issue_Dest.
- Issue_Ready = (count < PEND) || WB_Valid. When full, a same-cycle push and pop are both performed.
- WB_Valid pops the head. If count==0, or WB_Add != head addr, Err sets and stays set until reset. With count==0 there is no pop and no count change.
- History: HIST-deep shift register of {valid, addr, data}. Every cycle, entry0 <= {WB_Valid, WB_Add, WB_Data}, older entries shift; the oldest is dropped.
- Hazard for source Sx: some pending entry addr==Sx and that entry is not the head being popped this cycle with WB_Add==Sx. Req_Ready = !(hazard1 || hazard2).
- Value resolution per source, in priority order: live WB port (WB_Valid && WB_Add==Sx), then history newest→oldest by first valid match, else SourceDx.
- On an accepted request: Data1/Data2 <= resolved values, Out_Valid <= 1. Otherwise Out_Valid <= 0 and Data1/Data2 hold.
- Source_Add1==Source_Add2 resolves identically on both outputs.
- A duplicate destination in the FIFO is legal. The hazard persists until the last matching entry pops.

## Timing
- Reset (async assert, sync deassert by the integrator): count=0, FIFO contents don't-care, history valid=0, Data1=Data2=0, Out_Valid=0, Err=0, Issue_Ready=1, Req_Ready=1 (no hazard).
- Read latency: 1 cycle, accepted request at edge N gives Out_Valid/Data at N+1.
- Issue at edge N makes the hazard visible from cycle N+1. A same-cycle request is not blocked by that issue.
- WB in cycle N unblocks a waiting request in cycle N, forwarded from the port. The value is then served from history for HIST cycles.
- Req_Ready is combinational from addresses, FIFO state and WB. No path from Req_Valid to Req_Ready.
- Reset asserted mid-stall clears the scoreboard. Req_Ready returns to 1 immediately.

## Configuration
- RAW_ZERO_REG_EN defined: register address 0 is hardwired zero. Issues to address 0 are still pushed and popped but never cause a hazard. Source address 0 always yields Data=0, with no forwarding. History never matches address 0.
- Not defined: address 0 is an ordinary register.

## Test plan
- Reset, then request S1=3,S2=4, SourceD=0x1111/0x2222, no pending: Req_Ready=1; next cycle Data1=0x1111, Data2=0x2222, Out_Valid=1.
- Issue dest 5, then request S1=5: Req_Ready=0 held 3 cycles. WB 5/0xBEEF in cycle 4: Req_Ready=1 that cycle; next cycle Data1=0xBEEF.
- WB 7/0xA5A5, then request S2=7 with stale SourceD2=0 at cycles +1..+HIST: Data2=0xA5A5. At +HIST+1: Data2=SourceD2.
- Issue 4 writes (count=PEND): Issue_Ready=0. Issue with simultaneous in-order WB: accepted, count stays 4.
- Issue 2 then 3, WB 3 first: Err=1 and stays 1 through later correct WBs until Reset_n low.
- With RAW_ZERO_REG_EN, issue dest 0 and request S1=0, SourceD1=0xFFFF: Req_Ready=1, Data1=0. Without the macro: stall until WB 0.
